// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 16x oversampled, 5-8 data bits LSB-first,
// optional even/odd parity, one or two stop bits.
// Ports:
//   SCLK     in   system clock, rising edge
//   SCLR     in   asynchronous active-high reset
//   RX_EN    in   receiver enable, honoured only while idle
//   UMODE    in   [2] parity enable, [1] odd parity, [0] two stop bits
//   SMODE    in   data length 00=8 01=7 10=6 11=5
//   BMODE    in   one-hot baud select 1200..19200, highest bit wins, zero = 9600
//   RX       in   serial line, idle high, asynchronous
//   RX_DATA  out  received byte, right-justified
//   RX_DONE  out  one-cycle frame-complete strobe
//   RX_PERR  out  parity error of last frame
//   RX_FERR  out  framing error of last frame
//   RX_BUSY  out  frame in progress
module uart_rx #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       SCLK,
  input  logic       SCLR,
  input  logic       RX_EN,
  input  logic [2:0] UMODE,
  input  logic [1:0] SMODE,
  input  logic [4:0] BMODE,
  input  logic       RX,
  output logic [7:0] RX_DATA,
  output logic       RX_DONE,
  output logic       RX_PERR,
  output logic       RX_FERR,
  output logic       RX_BUSY
);

  localparam int unsigned DIV_1200  = (CLK_HZ + 8 * 1200)  / (16 * 1200);
  localparam int unsigned DIV_2400  = (CLK_HZ + 8 * 2400)  / (16 * 2400);
  localparam int unsigned DIV_4800  = (CLK_HZ + 8 * 4800)  / (16 * 4800);
  localparam int unsigned DIV_9600  = (CLK_HZ + 8 * 9600)  / (16 * 9600);
  localparam int unsigned DIV_19200 = (CLK_HZ + 8 * 19200) / (16 * 19200);
  localparam int unsigned CNT_W     = (DIV_1200 > 1) ? $clog2(DIV_1200) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP1 = 3'd4;
  localparam logic [2:0] S_STOP2 = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic             r_rx_meta;
  logic             r_rxs;
  logic             r_armed;
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [CNT_W-1:0] r_div_m1;
  logic [CNT_W-1:0] w_div_sel;
  logic [3:0]       r_os;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_perr;
  logic             r_ferr;
  logic [2:0]       r_umode;
  logic [1:0]       r_smode;

  logic w_counting;
  logic w_tick;
  logic w_start_det;
  logic w_start_smp;
  logic w_mid;
  logic w_last_bit;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rxs     <= r_rx_meta;
    end
  end

  // Baud divisor select, highest set bit wins
  always_comb begin
    w_div_sel = CNT_W'(DIV_9600 - 1);
    if (BMODE[4])      w_div_sel = CNT_W'(DIV_19200 - 1);
    else if (BMODE[3]) w_div_sel = CNT_W'(DIV_9600 - 1);
    else if (BMODE[2]) w_div_sel = CNT_W'(DIV_4800 - 1);
    else if (BMODE[1]) w_div_sel = CNT_W'(DIV_2400 - 1);
    else if (BMODE[0]) w_div_sel = CNT_W'(DIV_1200 - 1);
  end

  assign w_counting  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tick      = w_counting && (r_tick_cnt == r_div_m1);
  // Armed means the line has been seen high since the last frame or break
  assign w_start_det = (r_state == S_IDLE) && RX_EN && r_armed && !r_rxs;
  assign w_start_smp = (r_state == S_START) && w_tick && (r_os == 4'd7);
  assign w_mid       = w_tick && (r_os == 4'd15);
  assign w_last_bit  = (r_bit_cnt == (3'd7 - {1'b0, r_smode}));

  // State register
  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_det) w_next = S_START;
      S_START: if (w_start_smp) w_next = r_rxs ? S_IDLE : S_DATA;
      S_DATA:  if (w_mid && w_last_bit) w_next = r_umode[2] ? S_PAR : S_STOP1;
      S_PAR:   if (w_mid) w_next = S_STOP1;
      S_STOP1: if (w_mid) w_next = r_umode[0] ? S_STOP2 : S_DONE;
      S_STOP2: if (w_mid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Oversampling counters, frame datapath and registered outputs
  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      r_armed    <= 1'b0;
      r_tick_cnt <= '0;
      r_div_m1   <= CNT_W'(DIV_9600 - 1);
      r_os       <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_umode    <= 3'd0;
      r_smode    <= 2'd0;
      RX_DATA    <= 8'h00;
      RX_DONE    <= 1'b0;
      RX_PERR    <= 1'b0;
      RX_FERR    <= 1'b0;
      RX_BUSY    <= 1'b0;
    end else begin
      RX_DONE <= 1'b0;
      RX_BUSY <= (w_next != S_IDLE);

      if (!w_counting || w_tick) r_tick_cnt <= '0;
      else                       r_tick_cnt <= r_tick_cnt + CNT_W'(1);

      // Phase realigns to the start-bit centre so later samples land mid-bit
      if (!w_counting || w_start_smp) r_os <= 4'd0;
      else if (w_tick)                r_os <= r_os + 4'd1;

      case (r_state)
        S_IDLE: begin
          if (w_start_det) begin
            r_armed   <= 1'b0;
            r_umode   <= UMODE;
            r_smode   <= SMODE;
            r_div_m1  <= w_div_sel;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
          end else if (!RX_EN) begin
            r_armed <= r_rxs;
          end else if (r_rxs) begin
            r_armed <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_mid) begin
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_par     <= r_par ^ r_rxs;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_PAR: begin
          if (w_mid) r_perr <= r_rxs ^ r_par ^ r_umode[1];
        end
        S_STOP1, S_STOP2: begin
          if (w_mid) begin
            if (!r_rxs) r_ferr <= 1'b1;
            // A high stop bit lets a start edge right after it be accepted
            r_armed <= r_rxs;
          end
        end
        S_DONE: begin
          // Short frames sit in the top bits of the shifter; right-justify
          RX_DATA <= r_shift >> r_smode;
          RX_PERR <= r_perr;
          RX_FERR <= r_ferr;
          RX_DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_536_000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic [2:0] umode;
  logic [1:0] smode;
  logic [4:0] bmode;
  logic       rx;
  logic [7:0] RX_DATA;
  logic       RX_DONE;
  logic       RX_PERR;
  logic       RX_FERR;
  logic       RX_BUSY;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;
  int done_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

  uart_rx #(.CLK_HZ(CLK_HZ)) dut (
    .SCLK(clk), .SCLR(rst), .RX_EN(rx_en), .UMODE(umode), .SMODE(smode),
    .BMODE(bmode), .RX(rx), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
    .RX_PERR(RX_PERR), .RX_FERR(RX_FERR), .RX_BUSY(RX_BUSY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every completed frame away from the active edge
  always @(negedge clk) begin
    if (RX_DONE === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
      cap_data <= RX_DATA;
      cap_perr <= RX_PERR;
      cap_ferr <= RX_FERR;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int baud_of(input logic [4:0] b);
    for (int i = 4; i >= 0; i--) if (b[i]) return 1200 << i;
    return 9600;
  endfunction

  function automatic int div_of(input logic [4:0] b);
    int bd;
    bd = baud_of(b);
    return (int'(CLK_HZ) + 8 * bd) / (16 * bd);
  endfunction

  // Drive one frame and compare the receiver's result with the expected frame contents
  task automatic send_frame(input logic [7:0] data, input logic [2:0] um, input logic [1:0] sm,
                            input logic [4:0] bm, input bit flip_par, input logic [1:0] stop_lo,
                            input bit scramble);
    int div, bt, nb, ns, ones, t0, nd0, ticks;
    logic sp, e_perr, e_ferr;
    logic [7:0] e_data;
    div = div_of(bm);
    bt  = 16 * div;
    nb  = 8 - int'(sm);
    ns  = 1 + int'(um[0]);
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    sp = 1'(ones % 2) ^ um[1] ^ flip_par;
    umode = um; smode = sm; bmode = bm;
    nd0 = n_done;
    rx = 1'b0;
    t0 = cyc;
    step(bt / 2);
    if (scramble) begin
      umode = 3'($urandom); smode = 2'($urandom); bmode = 5'($urandom); rx_en = 1'b0;
    end
    step(bt - bt / 2);
    for (int i = 0; i < nb; i++) begin
      rx = data[i];
      if (i == 0) begin
        step(bt / 2);
        check("busy_mid_frame", 32'(RX_BUSY), 32'd1);
        step(bt - bt / 2);
      end else begin
        step(bt);
      end
    end
    if (um[2]) begin
      rx = sp;
      step(bt);
    end
    for (int s = 0; s < ns; s++) begin
      rx = ~stop_lo[s];
      step(bt);
    end
    rx = 1'b1;
    rx_en = 1'b1;
    e_data = 8'(data & 8'(((1 << nb) - 1)));
    e_perr = um[2] ? (((ones + int'(sp)) % 2) != int'(um[1])) : 1'b0;
    e_ferr = stop_lo[0] | (um[0] & stop_lo[1]);
    ticks  = (1 + nb + int'(um[2]) + ns - 1) * 16 + 8;
    check("done_count", 32'(n_done - nd0), 32'd1);
    check("rx_data", 32'(cap_data), 32'(e_data));
    check("rx_perr", 32'(cap_perr), 32'(e_perr));
    check("rx_ferr", 32'(cap_ferr), 32'(e_ferr));
    check_rng("done_latency", done_cyc - t0, ticks * div + 1, ticks * div + 6);
    last_perr = e_perr;
    last_ferr = e_ferr;
  endtask

  initial begin
    logic [4:0] bsel [5];
    int nd0, bt;
    logic [7:0] d;
    logic [2:0] um;
    logic [1:0] sm, slo;
    bit flip;
    bsel[0] = 5'b00100; bsel[1] = 5'b01000; bsel[2] = 5'b10000;
    bsel[3] = 5'b00000; bsel[4] = 5'b11010;

    rst = 1'b1; rx = 1'b1; rx_en = 1'b1; umode = 3'd0; smode = 2'd0; bmode = 5'b01000;
    step(3);
    check("reset_data", 32'(RX_DATA), 32'h00);
    check("reset_done", 32'(RX_DONE), 32'd0);
    check("reset_perr", 32'(RX_PERR), 32'd0);
    check("reset_ferr", 32'(RX_FERR), 32'd0);
    check("reset_busy", 32'(RX_BUSY), 32'd0);
    rst = 1'b0;
    step(10);

    bt = 16 * div_of(5'b01000);

    // 9600 8N1
    send_frame(8'hA1, 3'b000, 2'b00, 5'b01000, 1'b0, 2'b00, 1'b0);
    step(bt);
    // odd parity, correct then flipped
    send_frame(8'h3C, 3'b110, 2'b00, 5'b01000, 1'b0, 2'b00, 1'b0);
    step(bt);
    send_frame(8'h3C, 3'b110, 2'b00, 5'b01000, 1'b1, 2'b00, 1'b0);
    step(bt);
    // 5-bit, two stop bits, then second stop low
    send_frame(8'h15, 3'b001, 2'b11, 5'b01000, 1'b0, 2'b00, 1'b0);
    step(bt);
    send_frame(8'h15, 3'b001, 2'b11, 5'b01000, 1'b0, 2'b10, 1'b0);
    step(bt);

    // short glitch: 5 ticks low
    umode = 3'b000; smode = 2'b00; bmode = 5'b01000;
    nd0 = n_done;
    rx = 1'b0;
    step(3 * div_of(5'b01000));
    check("glitch_busy_high", 32'(RX_BUSY), 32'd1);
    step(2 * div_of(5'b01000));
    rx = 1'b1;
    step(2 * bt);
    check("glitch_no_done", 32'(n_done - nd0), 32'd0);
    check("glitch_busy_low", 32'(RX_BUSY), 32'd0);
    check("glitch_perr_hold", 32'(RX_PERR), 32'(last_perr));
    check("glitch_ferr_hold", 32'(RX_FERR), 32'(last_ferr));

    // break for three frame times
    nd0 = n_done;
    rx = 1'b0;
    step(3 * 10 * bt);
    check("break_done_once", 32'(n_done - nd0), 32'd1);
    check("break_ferr", 32'(cap_ferr), 32'd1);
    check("break_data", 32'(cap_data), 32'h00);
    check("break_busy_low", 32'(RX_BUSY), 32'd0);
    rx = 1'b1;
    step(bt);
    send_frame(8'h55, 3'b000, 2'b00, 5'b01000, 1'b0, 2'b00, 1'b0);
    step(bt);

    // receiver disabled: no frame accepted
    rx_en = 1'b0;
    nd0 = n_done;
    rx = 1'b0;
    step(3 * bt);
    rx = 1'b1;
    step(10 * bt);
    check("disabled_no_done", 32'(n_done - nd0), 32'd0);
    check("disabled_busy", 32'(RX_BUSY), 32'd0);
    rx_en = 1'b1;
    step(bt);

    // reset mid-DATA of an 0xF0 frame
    nd0 = n_done;
    rx = 1'b0; step(bt);
    rx = 1'b0; step(bt);
    rx = 1'b0; step(bt);
    rx = 1'b0; step(bt / 2);
    rst = 1'b1;
    #1;
    check("sclr_data", 32'(RX_DATA), 32'h00);
    check("sclr_busy", 32'(RX_BUSY), 32'd0);
    check("sclr_done", 32'(RX_DONE), 32'd0);
    check("sclr_ferr", 32'(RX_FERR), 32'd0);
    rx = 1'b1;
    step(3);
    rst = 1'b0;
    step(2 * bt);
    check("sclr_no_done", 32'(n_done - nd0), 32'd0);
    send_frame(8'hF0, 3'b000, 2'b00, 5'b01000, 1'b0, 2'b00, 1'b0);
    step(bt);

    // randomized frames, some back-to-back, some with config changes mid-frame
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      um   = 3'($urandom);
      sm   = 2'($urandom);
      flip = um[2] ? 1'($urandom_range(0, 1)) : 1'b0;
      slo  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      send_frame(d, um, sm, bsel[$urandom_range(0, 4)], flip, slo, 1'($urandom_range(0, 1)));
      if (slo[int'(um[0])] || $urandom_range(0, 1) == 1) step(2 * bt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
